kbd_event_ctrl: RTL and testbench

//  Sequencer between ps2_keyboard's scancode FIFO and downstream consumers (ascii map, 7-seg, text/VGA).

---
 rtl/kbd_event_ctrl_pkg.sv | 44 ++++
 rtl/kbd_event_ctrl_bcd2_counter.sv | 22 ++
 rtl/kbd_event_ctrl.sv | 169 ++++++++++++++++
 tb/tb_kbd_event_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_event_ctrl_pkg.sv
// Shared types and scancode constants for the keyboard event sequencer.
package kbd_event_ctrl_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned GAP_W  = 2;

  localparam logic [CODE_W-1:0] SC_EXT    = 8'hE0;
  localparam logic [CODE_W-1:0] SC_BRK    = 8'hF0;
  localparam logic [CODE_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [CODE_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [CODE_W-1:0] SC_CTRL   = 8'h14;
  localparam logic [CODE_W-1:0] SC_CAPS   = 8'h58;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_GAP,
    ST_DECODE,
    ST_EMIT
  } state_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              ext;
    logic              brk;
    logic              rep;
  } evt_t;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    logic [3:0] ones;
    logic [3:0] tens;
    ones = v[3:0];
    tens = v[7:4];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/kbd_event_ctrl_bcd2_counter.sv
// Two-digit BCD counter: synchronous clear, increment, wraps 99 -> 00.
module bcd2_counter
  import kbd_event_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] bcd
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd <= 8'h00;
    end else if (clr) begin
      bcd <= 8'h00;
    end else if (inc) begin
      bcd <= bcd2_inc(bcd);
    end
  end

endmodule

// File: rtl/kbd_event_ctrl.sv
// Pops PS/2 scancodes from the FIFO, folds E0/F0 prefixes into flags and
// emits one event per key action with modifier, held-key and press-count tracking.
module kbd_event_ctrl
  import kbd_event_ctrl_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned EMIT_REPEAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] kb_data,
  input  logic              kb_ready,
  input  logic              kb_overflow,
  output logic              kb_nextdata_n,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_ext,
  output logic              evt_break,
  output logic              evt_repeat,
  output logic              shift_o,
  output logic              ctrl_o,
  output logic              caps_o,
  output logic [CODE_W-1:0] held_code,
  output logic [7:0]        press_bcd,
  output logic              ovf_sticky,
  input  logic              ovf_clr
);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] byte_q, byte_d;
  logic              ext_f_q, ext_f_d;
  logic              brk_f_q, brk_f_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  evt_t              evt_q, evt_d;
  logic              shift_d, ctrl_d, caps_d;
  logic [CODE_W-1:0] held_d;
  logic              held_ext_q, held_ext_d;
  logic              nextdata_n_d, evt_valid_d, ovf_d;
  logic              inc_c, is_rep_c, is_shift_c;

  assign evt_code   = evt_q.code;
  assign evt_ext    = evt_q.ext;
  assign evt_break  = evt_q.brk;
  assign evt_repeat = evt_q.rep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      byte_q        <= '0;
      ext_f_q       <= 1'b0;
      brk_f_q       <= 1'b0;
      gap_q         <= '0;
      evt_q         <= '0;
      shift_o       <= 1'b0;
      ctrl_o        <= 1'b0;
      caps_o        <= 1'b0;
      held_code     <= '0;
      held_ext_q    <= 1'b0;
      kb_nextdata_n <= 1'b1;
      evt_valid     <= 1'b0;
      ovf_sticky    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      ext_f_q       <= ext_f_d;
      brk_f_q       <= brk_f_d;
      gap_q         <= gap_d;
      evt_q         <= evt_d;
      shift_o       <= shift_d;
      ctrl_o        <= ctrl_d;
      caps_o        <= caps_d;
      held_code     <= held_d;
      held_ext_q    <= held_ext_d;
      kb_nextdata_n <= nextdata_n_d;
      evt_valid     <= evt_valid_d;
      ovf_sticky    <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    ext_f_d    = ext_f_q;
    brk_f_d    = brk_f_q;
    gap_d      = gap_q;
    evt_d      = evt_q;
    shift_d    = shift_o;
    ctrl_d     = ctrl_o;
    caps_d     = caps_o;
    held_d     = held_code;
    held_ext_d = held_ext_q;
    inc_c      = 1'b0;
    // A make of the held key (ext bit included) is typematic; 00 means nothing held.
    is_rep_c   = !brk_f_q && (held_code != '0) && (byte_q == held_code) &&
                 (ext_f_q == held_ext_q);
    is_shift_c = !ext_f_q && ((byte_q == SC_LSHIFT) || (byte_q == SC_RSHIFT));

    case (state_q)
      ST_IDLE: begin
        if (kb_ready) begin
          byte_d  = kb_data;
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        gap_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_DECODE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (byte_q == SC_EXT) begin
          ext_f_d = 1'b1;
        end else if (byte_q == SC_BRK) begin
          brk_f_d = 1'b1;
        end else begin
          evt_d.code = byte_q;
          evt_d.ext  = ext_f_q;
          evt_d.brk  = brk_f_q;
          evt_d.rep  = is_rep_c;
          ext_f_d    = 1'b0;
          brk_f_d    = 1'b0;
          if (brk_f_q) begin
            if ((byte_q == held_code) && (ext_f_q == held_ext_q)) begin
              held_d     = '0;
              held_ext_d = 1'b0;
            end
            if (is_shift_c)         shift_d = 1'b0;
            if (byte_q == SC_CTRL)  ctrl_d  = 1'b0;
          end else begin
            if (is_shift_c)         shift_d = 1'b1;
            if (byte_q == SC_CTRL)  ctrl_d  = 1'b1;
            if (!is_rep_c) begin
              held_d     = byte_q;
              held_ext_d = ext_f_q;
              inc_c      = 1'b1;
              if ((byte_q == SC_CAPS) && !ext_f_q) caps_d = !caps_o;
            end
          end
          if (!(is_rep_c && (EMIT_REPEAT == 0))) state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (evt_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    nextdata_n_d = (state_d != ST_POP);
    evt_valid_d  = (state_d == ST_EMIT);
    ovf_d        = kb_overflow ? 1'b1 : (ovf_clr ? 1'b0 : ovf_sticky);
  end

  bcd2_counter u_press (
    .clk (clk),
    .rst (rst),
    .inc (inc_c),
    .clr (1'b0),
    .bcd (press_bcd)
  );

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Self-checking bench: two DUT variants (repeats emitted / dropped) against a scancode-stream model.
module tb_kbd_event_ctrl;

  localparam int DEPTH = 4096;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic       shift;
    logic       ctrl;
    logic       caps;
    logic [7:0] held;
    logic [7:0] bcd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, evt_ready, kb_overflow, ovf_clr;
  logic       kb_rdy [2];
  logic [7:0] kb_dat [2];
  logic       nd_n [2], ev_valid [2], ev_ext [2], ev_brk [2], ev_rep [2];
  logic       sh [2], ct [2], cp [2], ovf [2];
  logic [7:0] ev_code [2], held [2], press [2];

  int tests, fails;
  logic [7:0] fifo_mem [2][DEPTH];
  int         fifo_wr [2], fifo_rd [2];
  exp_t       exp_mem [2][DEPTH];
  int         exp_wr [2], exp_rd [2];
  int         evcnt [2], pulses [2];
  logic       hold [2], nd_low_prev [2];
  logic [11:0] saved [2];

  logic       m_ext [2], m_brk [2], m_shift [2], m_ctrl [2], m_caps [2], m_hext [2];
  logic [7:0] m_held [2];
  int         m_cnt [2];
  logic [7:0] pal [12];

  always #5 clk = ~clk;

  kbd_event_ctrl #(.GAP_CYCLES(1), .EMIT_REPEAT(1)) dut (
    .clk(clk), .rst(rst), .kb_data(kb_dat[0]), .kb_ready(kb_rdy[0]), .kb_overflow(kb_overflow),
    .kb_nextdata_n(nd_n[0]), .evt_valid(ev_valid[0]), .evt_ready(evt_ready),
    .evt_code(ev_code[0]), .evt_ext(ev_ext[0]), .evt_break(ev_brk[0]), .evt_repeat(ev_rep[0]),
    .shift_o(sh[0]), .ctrl_o(ct[0]), .caps_o(cp[0]), .held_code(held[0]), .press_bcd(press[0]),
    .ovf_sticky(ovf[0]), .ovf_clr(ovf_clr)
  );

  kbd_event_ctrl #(.GAP_CYCLES(2), .EMIT_REPEAT(0)) dut_nr (
    .clk(clk), .rst(rst), .kb_data(kb_dat[1]), .kb_ready(kb_rdy[1]), .kb_overflow(kb_overflow),
    .kb_nextdata_n(nd_n[1]), .evt_valid(ev_valid[1]), .evt_ready(evt_ready),
    .evt_code(ev_code[1]), .evt_ext(ev_ext[1]), .evt_break(ev_brk[1]), .evt_repeat(ev_rep[1]),
    .shift_o(sh[1]), .ctrl_o(ct[1]), .caps_o(cp[1]), .held_code(held[1]), .press_bcd(press[1]),
    .ovf_sticky(ovf[1]), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // Spec-level interpretation of one byte of the scancode stream for variant i.
  function automatic void model(input int i, input logic [7:0] b);
    exp_t e;
    logic rep;
    if (b == 8'hE0) m_ext[i] = 1'b1;
    else if (b == 8'hF0) m_brk[i] = 1'b1;
    else begin
      rep = !m_brk[i] && (m_held[i] != 8'h00) && (b == m_held[i]) && (m_ext[i] == m_hext[i]);
      if (m_brk[i]) begin
        if (b == m_held[i] && m_ext[i] == m_hext[i]) begin
          m_held[i] = 8'h00;
          m_hext[i] = 1'b0;
        end
        if (!m_ext[i] && (b == 8'h12 || b == 8'h59)) m_shift[i] = 1'b0;
        if (b == 8'h14) m_ctrl[i] = 1'b0;
      end else begin
        if (!m_ext[i] && (b == 8'h12 || b == 8'h59)) m_shift[i] = 1'b1;
        if (b == 8'h14) m_ctrl[i] = 1'b1;
        if (!rep) begin
          m_held[i] = b;
          m_hext[i] = m_ext[i];
          m_cnt[i]  = (m_cnt[i] + 1) % 100;
          if (b == 8'h58 && !m_ext[i]) m_caps[i] = !m_caps[i];
        end
      end
      if (!(rep && i == 1)) begin
        e.code = b;          e.ext  = m_ext[i];   e.brk = m_brk[i];  e.rep = rep;
        e.shift = m_shift[i]; e.ctrl = m_ctrl[i]; e.caps = m_caps[i];
        e.held = m_held[i];  e.bcd  = to_bcd(m_cnt[i]);
        exp_mem[i][12'(exp_wr[i])] = e;
        exp_wr[i]++;
      end
      m_ext[i] = 1'b0;
      m_brk[i] = 1'b0;
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 2; i++) begin
      fifo_mem[i][12'(fifo_wr[i])] = b;
      fifo_wr[i]++;
      model(i, b);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    evt_ready = 1'b1; kb_overflow = 1'b0; ovf_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fifo_wr[i] = 0; fifo_rd[i] = 0; exp_wr[i] = 0; exp_rd[i] = 0;
      evcnt[i] = 0; pulses[i] = 0;
      m_ext[i] = 0; m_brk[i] = 0; m_shift[i] = 0; m_ctrl[i] = 0; m_caps[i] = 0;
      m_hext[i] = 0; m_held[i] = 8'h00; m_cnt[i] = 0;
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drain(input string tag);
    int idle;
    idle = 0;
    for (int c = 0; c < 4000 && idle < 12; c++) begin
      tick();
      if (fifo_rd[0] == fifo_wr[0] && fifo_rd[1] == fifo_wr[1] &&
          exp_rd[0] == exp_wr[0] && exp_rd[1] == exp_wr[1] && !ev_valid[0] && !ev_valid[1])
        idle++;
      else
        idle = 0;
    end
    chk({tag, "_drain_timeout"}, 32'(idle < 12), 32'd0);
  endtask

  // Monitor + FIFO model: checks events at transfer, stability under stall, pop strobes.
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          hold[i] = 1'b0; nd_low_prev[i] = 1'b0; kb_rdy[i] = 1'b0; kb_dat[i] = 8'h00;
        end else begin
          if (hold[i])
            chk($sformatf("stable%0d", i),
                32'({ev_valid[i], ev_code[i], ev_ext[i], ev_brk[i], ev_rep[i]}), 32'(saved[i]));
          if (ev_valid[i] && evt_ready) begin
            if (exp_rd[i] == exp_wr[i]) begin
              chk($sformatf("extra_event%0d", i), 32'(ev_code[i]), 32'h100);
            end else begin
              e = exp_mem[i][12'(exp_rd[i])];
              exp_rd[i]++;
              g.code = ev_code[i]; g.ext = ev_ext[i]; g.brk = ev_brk[i]; g.rep = ev_rep[i];
              g.shift = sh[i]; g.ctrl = ct[i]; g.caps = cp[i]; g.held = held[i]; g.bcd = press[i];
              chk($sformatf("evt%0d_%0d", i, evcnt[i]), 32'(g), 32'(e));
            end
            evcnt[i]++;
          end
          hold[i]  = ev_valid[i] && !evt_ready;
          saved[i] = {ev_valid[i], ev_code[i], ev_ext[i], ev_brk[i], ev_rep[i]};
          if (!nd_n[i]) begin
            pulses[i]++;
            chk($sformatf("pop_width%0d", i), 32'(nd_low_prev[i]), 32'd0);
            chk($sformatf("pop_in_emit%0d", i), 32'(ev_valid[i]), 32'd0);
            if (fifo_rd[i] != fifo_wr[i]) fifo_rd[i]++;
            else chk($sformatf("pop_empty%0d", i), 32'd1, 32'd0);
          end
          nd_low_prev[i] = !nd_n[i];
          kb_rdy[i] = (fifo_rd[i] != fifo_wr[i]);
          kb_dat[i] = fifo_mem[i][12'(fifo_rd[i])];
        end
      end
    end
  end

  initial begin
    logic got_pop;
    tests = 0; fails = 0;
    pal = '{8'hE0, 8'hF0, 8'h1C, 8'h1C, 8'h32, 8'h12, 8'h59, 8'h14, 8'h58, 8'hE1, 8'h75, 8'hF0};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_nd_n%0d", i), 32'(nd_n[i]), 32'd1);
      chk($sformatf("rst_outs%0d", i), 32'({ev_valid[i], ev_code[i], ev_ext[i], ev_brk[i],
          ev_rep[i], sh[i], ct[i], cp[i], held[i], ovf[i]}), 32'd0);
      chk($sformatf("rst_press%0d", i), 32'(press[i]), 32'd0);
    end

    push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
    drain("t1");
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t1_press%0d", i), 32'(press[i]), 32'h01);
      chk($sformatf("t1_held%0d", i), 32'(held[i]), 32'h00);
      chk($sformatf("t1_events%0d", i), 32'(evcnt[i]), 32'd2);
    end

    do_reset();
    push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
    drain("t2");
    chk("t2_events_rep", 32'(evcnt[0]), 32'd4);
    chk("t2_events_norep", 32'(evcnt[1]), 32'd2);
    for (int i = 0; i < 2; i++) chk($sformatf("t2_press%0d", i), 32'(press[i]), 32'h01);

    do_reset();
    push_byte(8'hE0); push_byte(8'h75); push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
    drain("t3");
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t3_events%0d", i), 32'(evcnt[i]), 32'd2);
      chk($sformatf("t3_pulses%0d", i), 32'(pulses[i]), 32'd5);
    end

    do_reset();
    push_byte(8'h12); push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h12);
    drain("t4");
    chk("t4_shift_off", 32'(sh[0]), 32'd0);
    push_byte(8'h58); push_byte(8'hF0); push_byte(8'h58);
    drain("t4b");
    chk("t4_caps_on", 32'(cp[0]), 32'd1);
    push_byte(8'h58); push_byte(8'hF0); push_byte(8'h58);
    drain("t4c");
    chk("t4_caps_off", 32'(cp[0]), 32'd0);

    do_reset();
    evt_ready = 1'b0;
    push_byte(8'h1C); push_byte(8'h32); push_byte(8'h21);
    repeat (20) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("bp_valid%0d", i), 32'(ev_valid[i]), 32'd1);
      chk($sformatf("bp_nopop%0d", i), 32'(fifo_wr[i] - fifo_rd[i]), 32'd2);
      chk($sformatf("bp_nd_n%0d", i), 32'(nd_n[i]), 32'd1);
      chk($sformatf("bp_events%0d", i), 32'(evcnt[i]), 32'd0);
    end
    evt_ready = 1'b1;
    drain("bp");
    chk("bp_events_after", 32'(evcnt[0]), 32'd3);

    kb_overflow = 1'b1; tick(); kb_overflow = 1'b0; tick();
    chk("ovf_set", 32'(ovf[0]), 32'd1);
    kb_overflow = 1'b1; ovf_clr = 1'b1; tick(); kb_overflow = 1'b0;
    chk("ovf_set_wins", 32'(ovf[1]), 32'd1);
    tick(); ovf_clr = 1'b0; tick();
    chk("ovf_cleared", 32'({ovf[0], ovf[1]}), 32'd0);

    do_reset();
    for (int k = 0; k < 100; k++) begin
      push_byte(8'(k + 1)); push_byte(8'hF0); push_byte(8'(k + 1));
      if (k == 98) begin
        drain("p99");
        chk("press_99", 32'(press[0]), 32'h99);
      end
    end
    drain("p100");
    chk("press_wrap", 32'({press[0], press[1]}), 32'h0000);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) == 0) push_byte(pal[$urandom_range(0, 11)]);
      evt_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    evt_ready = 1'b1;
    drain("rand");

    push_byte(8'h3A);
    got_pop = 1'b0;
    for (int c = 0; c < 20 && !got_pop; c++) begin
      tick();
      got_pop = !nd_n[0];
    end
    chk("rst_pop_reached", 32'(got_pop), 32'd1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_pop_nd_n%0d", i), 32'(nd_n[i]), 32'd1);
      chk($sformatf("rst_pop_outs%0d", i), 32'({ev_valid[i], sh[i], ct[i], cp[i], held[i],
          press[i], ovf[i]}), 32'd0);
    end
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
